// File: rtl/loader_pkg.sv
// Shared constants and enumerations for the UART program loader.
package loader_pkg;

    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [3:0] {
        OP_WRITE = 4'h1,
        OP_RUN   = 4'h2
    } loader_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CHK
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_FRAME   = 2'd0,
        ERR_BADCMD  = 2'd1,
        ERR_CHKSUM  = 2'd2,
        ERR_TIMEOUT = 2'd3
    } loader_err_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with two-flop synchroniser and mid-bit sampling.
// Emits a 1-cycle valid_o per good byte or a 1-cycle frame_err_o on a low stop bit.
module uart_rx #(
    parameter int ClkPerBit = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int CntWidth = $clog2(ClkPerBit + 1);
    localparam logic [CntWidth-1:0] HalfLast = CntWidth'(ClkPerBit / 2 - 1);
    localparam logic [CntWidth-1:0] BitLast  = CntWidth'(ClkPerBit - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t           state, state_next;
    logic                rx_meta, rx_sync, rx_prev;
    logic [CntWidth-1:0] cnt, cnt_next;
    logic [2:0]          bit_idx, bit_idx_next;
    logic [7:0]          shift, shift_next;
    logic                valid_next, frame_err_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            state       <= RX_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            rx_meta     <= rx_i;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
            state       <= state_next;
            cnt         <= cnt_next;
            bit_idx     <= bit_idx_next;
            shift       <= shift_next;
            valid_o     <= valid_next;
            frame_err_o <= frame_err_next;
        end
    end

    // Start needs a real falling edge, so a line held low after a bad stop bit cannot retrigger.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        bit_idx_next   = bit_idx;
        shift_next     = shift;
        valid_next     = 1'b0;
        frame_err_next = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_next = RX_START;
                    cnt_next   = '0;
                end
            end
            RX_START: begin
                if (cnt == HalfLast) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt + CntWidth'(1);
                end
            end
            RX_DATA: begin
                if (cnt == BitLast) begin
                    cnt_next     = '0;
                    shift_next   = {rx_sync, shift[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = RX_STOP;
                end else begin
                    cnt_next = cnt + CntWidth'(1);
                end
            end
            RX_STOP: begin
                if (cnt == BitLast) begin
                    cnt_next       = '0;
                    state_next     = RX_IDLE;
                    valid_next     = rx_sync;
                    frame_err_next = !rx_sync;
                end else begin
                    cnt_next = cnt + CntWidth'(1);
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign data_o = shift;

endmodule

// File: rtl/mem_loader.sv
// In-system program loader: decodes checksummed UART frames into byte writes on
// per-target debug ports, holding the core until a RUN command releases it.
module mem_loader #(
    parameter int NumTargets    = 2,
    parameter int AddrWidth     = 12,
    parameter int ClkPerBit     = 868,
    parameter int TimeoutCycles = 1_000_000,
    parameter bit HoldOnReset   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_i,
    input  logic                  err_clear_i,
    output logic [NumTargets-1:0] debug_o,
    output logic [AddrWidth-1:0]  debug_addr_o,
    output logic [7:0]            debug_data_o,
    output logic                  cpu_hold_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o
);
    import loader_pkg::*;

    localparam int AddrBytes = (AddrWidth + 7) / 8;
    localparam int AddrBufW  = AddrBytes * 8;
    localparam int AddrIdxW  = (AddrBytes > 1) ? $clog2(AddrBytes) : 1;
    localparam logic [AddrIdxW-1:0] AddrIdxLast = AddrIdxW'(AddrBytes - 1);
    localparam int TimeoutW  = $clog2(TimeoutCycles + 1);
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TimeoutCycles - 1);

    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err;

    uart_rx #(.ClkPerBit(ClkPerBit)) u_rx (
        .clk         (clk),
        .reset       (reset),
        .rx_i        (rx_i),
        .data_o      (rx_data),
        .valid_o     (rx_valid),
        .frame_err_o (rx_frame_err)
    );

    loader_state_t         state, state_next;
    logic                  is_run, is_run_next;
    logic [3:0]            target, target_next;
    logic [AddrBufW-1:0]   addr_buf, addr_buf_next;
    logic [AddrIdxW-1:0]   addr_idx, addr_idx_next;
    logic [15:0]           len, len_next;
    logic [7:0]            chk, chk_next;
    logic [TimeoutW-1:0]   tcnt, tcnt_next;
    logic [NumTargets-1:0] debug_next;
    logic [AddrWidth-1:0]  debug_addr_next;
    logic [7:0]            debug_data_next;
    logic                  hold_next, err_next;
    logic [1:0]            err_code_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            is_run       <= 1'b0;
            target       <= '0;
            addr_buf     <= '0;
            addr_idx     <= '0;
            len          <= '0;
            chk          <= '0;
            tcnt         <= '0;
            debug_o      <= '0;
            debug_addr_o <= '0;
            debug_data_o <= '0;
            cpu_hold_o   <= HoldOnReset;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
            err_code_o   <= '0;
        end else begin
            state        <= state_next;
            is_run       <= is_run_next;
            target       <= target_next;
            addr_buf     <= addr_buf_next;
            addr_idx     <= addr_idx_next;
            len          <= len_next;
            chk          <= chk_next;
            tcnt         <= tcnt_next;
            debug_o      <= debug_next;
            debug_addr_o <= debug_addr_next;
            debug_data_o <= debug_data_next;
            cpu_hold_o   <= hold_next;
            busy_o       <= (state_next != ST_IDLE);
            err_o        <= err_next;
            err_code_o   <= err_code_next;
        end
    end

    // Error sources are evaluated after err_clear_i so a same-cycle error keeps err_o set.
    always_comb begin
        state_next      = state;
        is_run_next     = is_run;
        target_next     = target;
        addr_buf_next   = addr_buf;
        addr_idx_next   = addr_idx;
        len_next        = len;
        chk_next        = chk;
        tcnt_next       = tcnt;
        debug_next      = '0;
        debug_addr_next = debug_addr_o;
        debug_data_next = debug_data_o;
        hold_next       = cpu_hold_o;
        err_next        = err_o;
        err_code_next   = err_code_o;

        if (err_clear_i) err_next = 1'b0;

        if (state == ST_IDLE || rx_valid) tcnt_next = '0;
        else if (tcnt != TimeoutLast)     tcnt_next = tcnt + TimeoutW'(1);

        if (rx_frame_err) begin
            err_next      = 1'b1;
            err_code_next = ERR_FRAME;
            state_next    = ST_IDLE;
        end else if (state != ST_IDLE && !rx_valid && tcnt == TimeoutLast) begin
            err_next      = 1'b1;
            err_code_next = ERR_TIMEOUT;
            state_next    = ST_IDLE;
        end else if (rx_valid) begin
            unique case (state)
                ST_IDLE: begin
                    if (rx_data == SYNC) state_next = ST_CMD;
                end
                ST_CMD: begin
                    chk_next    = rx_data;
                    target_next = rx_data[3:0];
                    if (rx_data[7:4] == OP_WRITE && int'(rx_data[3:0]) < NumTargets) begin
                        is_run_next   = 1'b0;
                        hold_next     = 1'b1;
                        addr_idx_next = '0;
                        state_next    = ST_ADDR;
                    end else if (rx_data[7:4] == OP_RUN) begin
                        is_run_next = 1'b1;
                        state_next  = ST_CHK;
                    end else begin
                        err_next      = 1'b1;
                        err_code_next = ERR_BADCMD;
                        state_next    = ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    chk_next      = chk ^ rx_data;
                    addr_buf_next = (addr_buf >> 8) | (AddrBufW'(rx_data) << (AddrBufW - 8));
                    if (addr_idx == AddrIdxLast) state_next = ST_LEN0;
                    else addr_idx_next = addr_idx + AddrIdxW'(1);
                end
                ST_LEN0: begin
                    chk_next      = chk ^ rx_data;
                    len_next[7:0] = rx_data;
                    state_next    = ST_LEN1;
                end
                ST_LEN1: begin
                    chk_next       = chk ^ rx_data;
                    len_next[15:8] = rx_data;
                    state_next     = ({rx_data, len[7:0]} == 16'd0) ? ST_CHK : ST_DATA;
                end
                ST_DATA: begin
                    chk_next = chk ^ rx_data;
                    for (int t = 0; t < NumTargets; t++) begin
                        if (int'(target) == t) debug_next[t] = 1'b1;
                    end
                    debug_addr_next = addr_buf[AddrWidth-1:0];
                    debug_data_next = rx_data;
                    addr_buf_next[AddrWidth-1:0] = addr_buf[AddrWidth-1:0] + AddrWidth'(1);
                    len_next = len - 16'd1;
                    if (len == 16'd1) state_next = ST_CHK;
                end
                ST_CHK: begin
                    state_next = ST_IDLE;
                    if (rx_data != chk) begin
                        err_next      = 1'b1;
                        err_code_next = ERR_CHKSUM;
                    end else if (is_run) begin
                        hold_next = 1'b0;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader driving framed UART bytes on rx_i.
module tb_mem_loader;

    localparam int C = 8;
    localparam int T = 400;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        err_clear;
    logic [1:0]  debug;
    logic [11:0] debug_addr;
    logic [7:0]  debug_data;
    logic        cpu_hold, busy, err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    logic [1:0]  s_tgt[$];
    logic [11:0] s_addr[$];
    logic [7:0]  s_data[$];
    logic [7:0]  frame[$];
    logic [1:0]  prev_debug = 2'b00;
    int          bad_strobes = 0;
    int          err_high_cycles = 0;
    logic        window = 1'b0;
    int          base;

    always #5 clk = ~clk;

    mem_loader #(
        .NumTargets(2), .AddrWidth(12), .ClkPerBit(C), .TimeoutCycles(T), .HoldOnReset(1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_i         (rx),
        .err_clear_i  (err_clear),
        .debug_o      (debug),
        .debug_addr_o (debug_addr),
        .debug_data_o (debug_data),
        .cpu_hold_o   (cpu_hold),
        .busy_o       (busy),
        .err_o        (err),
        .err_code_o   (err_code)
    );

    // Strobe recorder; also flags multi-cycle or multi-target strobes.
    always @(negedge clk) begin
        if (debug != 2'b00) begin
            s_tgt.push_back(debug);
            s_addr.push_back(debug_addr);
            s_data.push_back(debug_data);
            if ($countones(debug) != 1 || prev_debug != 2'b00) bad_strobes++;
        end
        prev_debug = debug;
        if (window && err) err_high_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        @(negedge clk); rx = 1'b0; repeat (C - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); rx = b[i]; repeat (C - 1) @(negedge clk);
        end
        @(negedge clk); rx = stop_bit; repeat (C - 1) @(negedge clk);
        @(negedge clk); rx = 1'b1; repeat (3) @(negedge clk);
    endtask

    task automatic send_frame();
        foreach (frame[i]) send_byte(frame[i]);
    endtask

    task automatic check_strobe(input int idx, input logic [1:0] tgt, input logic [11:0] a, input logic [7:0] d);
        if (idx < s_tgt.size()) begin
            check($sformatf("strobe%0d_tgt", idx), s_tgt[idx], tgt);
            check($sformatf("strobe%0d_addr", idx), s_addr[idx], a);
            check($sformatf("strobe%0d_data", idx), s_data[idx], d);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_debug"}, debug, 2'b00);
        check({tag, "_addr"}, debug_addr, 12'h000);
        check({tag, "_data"}, debug_data, 8'h00);
        check({tag, "_hold"}, cpu_hold, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_code"}, err_code, 2'd0);
    endtask

    task automatic pulse_clear();
        @(negedge clk); err_clear = 1'b1;
        @(negedge clk); err_clear = 1'b0;
        idle(1);
    endtask

    initial begin
        rx = 1'b1; err_clear = 1'b0; reset = 1'b1;
        idle(3);
        check_reset_values("reset");
        reset = 1'b0;
        idle(5);

        // WRITE target 0, addr 0x010, payload 11 22 33
        base = s_tgt.size();
        send_byte(8'hA5);
        idle(1);
        check("busy_after_sync", busy, 1'b1);
        frame = '{8'h10, 8'h10, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h03};
        send_frame();
        idle(5);
        check("f1_count", s_tgt.size(), base + 3);
        check_strobe(base + 0, 2'b01, 12'h010, 8'h11);
        check_strobe(base + 1, 2'b01, 12'h011, 8'h22);
        check_strobe(base + 2, 2'b01, 12'h012, 8'h33);
        check("f1_hold", cpu_hold, 1'b1);
        check("f1_err", err, 1'b0);
        check("f1_busy", busy, 1'b0);

        // WRITE target 1 with address wrap
        base = s_tgt.size();
        frame = '{8'hA5, 8'h11, 8'hFF, 8'h0F, 8'h02, 8'h00, 8'hAA, 8'h55, 8'h1C};
        send_frame();
        idle(5);
        check("f2_count", s_tgt.size(), base + 2);
        check_strobe(base + 0, 2'b10, 12'hFFF, 8'hAA);
        check_strobe(base + 1, 2'b10, 12'h000, 8'h55);
        check("f2_err", err, 1'b0);

        // RUN good releases the core
        frame = '{8'hA5, 8'h20, 8'h20};
        send_frame();
        idle(2);
        check("run_hold", cpu_hold, 1'b0);
        check("run_err", err, 1'b0);

        // Zero-length WRITE re-asserts hold without strobes
        base = s_tgt.size();
        frame = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
        send_frame();
        idle(2);
        check("len0_hold", cpu_hold, 1'b1);
        check("len0_count", s_tgt.size(), base);
        check("len0_err", err, 1'b0);

        // RUN with bad checksum
        frame = '{8'hA5, 8'h20, 8'h21};
        send_frame();
        idle(2);
        check("runbad_hold", cpu_hold, 1'b1);
        check("runbad_err", err, 1'b1);
        check("runbad_code", err_code, 2'd2);
        pulse_clear();
        check("clear_err", err, 1'b0);
        check("clear_code", err_code, 2'd2);

        // Bad target then a normal frame
        base = s_tgt.size();
        frame = '{8'hA5, 8'h13};
        send_frame();
        idle(3);
        check("badcmd_err", err, 1'b1);
        check("badcmd_code", err_code, 2'd1);
        check("badcmd_busy", busy, 1'b0);
        check("badcmd_count", s_tgt.size(), base);
        frame = '{8'hA5, 8'h10, 8'h20, 8'h00, 8'h01, 8'h00, 8'h7E, 8'h4F};
        send_frame();
        idle(3);
        check("after_bad_count", s_tgt.size(), base + 1);
        check_strobe(base, 2'b01, 12'h020, 8'h7E);
        check("after_bad_code", err_code, 2'd1);

        // Corrupted stop bit mid-payload
        pulse_clear();
        base = s_tgt.size();
        frame = '{8'hA5, 8'h10, 8'h30, 8'h00, 8'h03, 8'h00, 8'h01};
        send_frame();
        send_byte(8'h02, 1'b0);
        idle(5);
        check("frame_err", err, 1'b1);
        check("frame_code", err_code, 2'd0);
        check("frame_busy", busy, 1'b0);
        check("frame_count", s_tgt.size(), base + 1);
        check_strobe(base, 2'b01, 12'h030, 8'h01);

        // Stall after LEN
        pulse_clear();
        frame = '{8'hA5, 8'h10, 8'h40, 8'h00, 8'h02, 8'h00};
        send_frame();
        idle(T - 10);
        check("tmo_early_err", err, 1'b0);
        check("tmo_early_busy", busy, 1'b1);
        idle(10);
        check("tmo_err", err, 1'b1);
        check("tmo_code", err_code, 2'd3);
        check("tmo_busy", busy, 1'b0);

        // New error while err_clear_i is held high
        @(negedge clk); err_clear = 1'b1;
        @(negedge clk); window = 1'b1;
        frame = '{8'hA5, 8'h13};
        send_frame();
        idle(3);
        window = 1'b0;
        check("collide_err_cycles", err_high_cycles, 1);
        check("collide_code", err_code, 2'd1);
        err_clear = 1'b0;
        idle(1);
        check("collide_cleared", err, 1'b0);

        // Reset mid-DATA
        base = s_tgt.size();
        frame = '{8'hA5, 8'h10, 8'h50, 8'h00, 8'h04, 8'h00, 8'h01, 8'h02};
        send_frame();
        @(negedge clk); rx = 1'b0;
        idle(20);
        reset = 1'b1;
        idle(2);
        check_reset_values("midreset");
        rx = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(100);
        check("midreset_count", s_tgt.size(), base + 2);
        check("midreset_busy", busy, 1'b0);
        frame = '{8'hA5, 8'h10, 8'h60, 8'h00, 8'h01, 8'h00, 8'h9C, 8'hED};
        send_frame();
        idle(3);
        check("fresh_count", s_tgt.size(), base + 3);
        check_strobe(base + 2, 2'b01, 12'h060, 8'h9C);
        check("fresh_hold", cpu_hold, 1'b1);
        check("fresh_err", err, 1'b0);

        check("strobe_shape", bad_strobes, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
# mem_loader

Parametrised in-system program loader that generalises the core's single-byte debug write port. It receives framed packets over a UART line, holds the CPU while loading, and streams byte writes into any of `NumTargets` memories (imem, dmem, …). It validates each frame with a checksum and releases the core on a `RUN` command. It sits between the board RX pin and the memory debug write ports.

## Interface
Parameters:
- `NumTargets`, 2, number of writable memories; target index 0 = imem, 1 = dmem.
- `AddrWidth`, 12, byte address width of every target.
- `ClkPerBit`, 868, clock cycles per UART bit (100 MHz / 115200).
- `TimeoutCycles`, 1_000_000, maximum idle gap between bytes inside a frame.
- `HoldOnReset`, 1, value of `cpu_hold_o` after reset.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_i`  in  1  UART RX line, idle high; asynchronous to `clk`.
- `err_clear_i`  in  1  clears `err_o`.
- `debug_o`  out  `NumTargets`  one-hot write strobe, one bit per target.
- `debug_addr_o`  out  `AddrWidth`  byte write address.
- `debug_data_o`  out  8  write data.
- `cpu_hold_o`  out  1  core held (pc/debug mux forced) while high.
- `busy_o`  out  1  high whenever the FSM is not IDLE.
- `err_o`  out  1  sticky error flag.
- `err_code_o`  out  2  last error: 0 FRAME, 1 BADCMD, 2 CHKSUM, 3 TIMEOUT.

## Operation
**UART RX**
- Two-flop synchroniser on `rx_i`.
- Start is the falling edge; the start bit is re-checked at mid-bit (`ClkPerBit/2`), and a glitch returns the receiver to idle.
- 8 data bits, LSB first, each sampled at mid-bit. Then a stop bit.
- Stop bit low: byte discarded, FRAME error.
- Each good byte produces a 1-cycle `byte_valid`.

**Frame format**
- Fields in order: `SYNC(0xA5)`, `CMD`, `ADDR`, `LEN`, `PAYLOAD`, `CHK`.
- `CMD[7:4]` is the opcode: 0x1 WRITE, 0x2 RUN. `CMD[3:0]` is the target.
- `ADDR` is `ceil(AddrWidth/8)` bytes, little-endian. Unused high bits are ignored.
- `LEN` is 2 bytes, little-endian, giving the payload byte count N.
- `CHK` is the XOR of every byte from `CMD` to the last payload byte.
- RUN frames carry only `SYNC`, `CMD`, `CHK`.

**FSM states:** IDLE → CMD → ADDR → LEN0 → LEN1 → DATA → CHK → IDLE.
- IDLE: bytes other than 0xA5 are ignored.
- CMD:
  - Opcode other than WRITE/RUN, or a WRITE with target ≥ `NumTargets`: BADCMD, go to IDLE.
  - Valid WRITE: `cpu_hold_o` ← 1 immediately.
  - RUN: go directly to CHK.
- LEN1: if N = 0, go to CHK; otherwise go to DATA.
- DATA, per byte:
  - `debug_o[target]` pulses for one cycle with the current address and data.
  - The address then increments, wrapping modulo 2^`AddrWidth`.
  - The remaining count decrements; when it reaches 0, go to CHK.
- CHK:
  - Mismatch: CHKSUM error; payload already written stays written.
  - Match on RUN: `cpu_hold_o` ← 0.
  - Match on WRITE: no further action.

**Abort conditions**
- A FRAME error in any non-IDLE state aborts the frame to IDLE.
- A gap of `TimeoutCycles` without `byte_valid` in any non-IDLE state: TIMEOUT, go to IDLE.
- Aborts never change `cpu_hold_o`.

**Errors**
- Any error sets `err_o` and overwrites `err_code_o`.
- `err_clear_i` clears `err_o` only.
- A new error in the same cycle as `err_clear_i` wins.

## Timing
- Reset values:
  - `debug_o`=0, `debug_addr_o`=0, `debug_data_o`=0.
  - `busy_o`=0, `err_o`=0, `err_code_o`=0.
  - `cpu_hold_o`=`HoldOnReset`.
  - FSM in IDLE, receiver idle, timeout counter 0.
- Reset mid-frame: the frame is dropped silently and no strobe is emitted after reset.
- `byte_valid` fires 2 sync cycles + 9.5 bit times after the start edge.
- All outputs are registered. `debug_o` and `cpu_hold_o` change on the cycle after `byte_valid`.
- `debug_o` is never asserted for more than 1 cycle per byte, and is never asserted on two targets at once.
- `busy_o` rises the cycle after SYNC is accepted and falls the cycle after the CHK byte or an abort.
- The timeout counter resets on every `byte_valid` and saturates.

## Structure
- `loader_pkg` holds:
  - `SYNC` = 8'hA5;
  - the `loader_op_t` enum (WRITE, RUN);
  - the `loader_state_t` enum;
  - the `loader_err_t` enum.
- Sub-module `uart_rx`:
  - parameter `ClkPerBit`;
  - ports `clk`, `reset`, `rx_i`, `data_o[7:0]`, `valid_o`, `frame_err_o`;
  - reusable by later UART blocks.
- Top level: `mem_loader` holds the FSM, address/length counters, checksum, timeout and output registers.

## Test plan
- WRITE, target 0, addr 0x010, LEN 3, payload 11 22 33, correct CHK:
  - three 1-cycle `debug_o`=2'b01 strobes at addr 0x010/0x011/0x012 with data 0x11/0x22/0x33;
  - `cpu_hold_o`=1; `err_o`=0.
- WRITE, target 1, addr 0xFFF, LEN 2:
  - strobes on `debug_o`=2'b10 at 0xFFF, then at 0x000 (wrap).
- RUN with correct CHK after a load: `cpu_hold_o` falls 1 cycle after the CHK `byte_valid`. RUN with bad CHK: hold stays 1, `err_code_o`=2.
- CMD 0x13 (target 3 with `NumTargets`=2): `err_code_o`=1, no strobe; the next valid frame is processed normally.
- Corrupted stop bit mid-payload: FRAME error, return to IDLE. Stall after LEN: TIMEOUT at exactly `TimeoutCycles`. `err_clear_i` pulsed together with a new error: `err_o` stays 1.
- `reset` asserted mid-DATA: all outputs at reset values, no further strobes; a fresh frame after release is loaded correctly.
